// File: rtl/ro_meter_pkg.sv
// ro_meter_pkg: shared definitions for the ring-oscillator frequency meter.
//   - state_e       : measurement FSM encoding (IDLE, SETTLE, GATE)
//   - WIN_BASE_EXP  : gate window is 2^(win_sel + WIN_BASE_EXP) clk cycles
//   - WIN_CNT_W     : width of the settle/window cycle counter
//   - bin2gray / gray2bin : code conversion, 32-bit wide; callers truncate
`timescale 1ns/1ps
package ro_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2
  } state_e;

  localparam int WIN_BASE_EXP = 4;
  localparam int WIN_CNT_W    = 20;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs convert correctly, so narrower counters can
  // use this by casting in and out.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: counts ro_clk rising edges and delivers the count into
// the clk domain.
//   clk    : system clock (synchroniser side)
//   rst_n  : async active-low reset, clears both domains
//   ro_clk : ring oscillator output, asynchronous to clk
//   cur    : binary edge count, clk domain, two cycles of lag
// The count crosses as Gray code, so a sample taken mid-transition is off
// by at most one edge. This is the only logic clocked by ro_clk.
`timescale 1ns/1ps
module ro_edge_counter
  import ro_meter_pkg::*;
#(
  parameter int RO_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ro_clk,
  output logic [RO_CNT_W-1:0] cur
);

  logic [RO_CNT_W-1:0]       bin_q, bin_nxt, gray_q;
  logic [1:0][RO_CNT_W-1:0]  sync_q;

  assign bin_nxt = bin_q + RO_CNT_W'(1);

  // Gray value is registered, never combinational, so the crossing
  // source is glitch-free.
  always_ff @(posedge ro_clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= RO_CNT_W'(bin2gray(32'(bin_nxt)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], gray_q};
  end

  assign cur = RO_CNT_W'(gray2bin(32'(sync_q[1])));

endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: ring-oscillator frequency meter.
//   clk, rst_n : system clock, async active-low reset
//   start      : request a measurement (ignored while busy)
//   win_sel    : gate window N = 2^(win_sel+4) clk cycles, latched on start
//   ro_clk     : oscillator output (held low while ro_en = 0)
//   ro_en      : oscillator enable, registered
//   busy       : measurement in progress (SETTLE or GATE)
//   done       : one-cycle pulse when result/overflow update
//   result     : ro_clk rising edges counted in the last window, saturating
//   overflow   : last window saturated result
// Flow: IDLE -> SETTLE (SETTLE_CYCLES, oscillator warming up, edges
// discarded) -> GATE (N cycles, per-cycle deltas accumulated) -> IDLE.
`timescale 1ns/1ps
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int RO_CNT_W      = 8,
  parameter int ACC_W         = 24,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       win_sel,
  input  logic             ro_clk,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  localparam logic [WIN_CNT_W-1:0] SETTLE_LAST = WIN_CNT_W'(SETTLE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [WIN_CNT_W-1:0]  cnt_q, cnt_d, win_last_q;
  logic                  done_d;

  logic [RO_CNT_W-1:0]   cur, prev_q, delta;
  logic [ACC_W-1:0]      acc_q, acc_nxt;
  logic [ACC_W:0]        sum;
  logic                  sat_q, sat_hit;

  ro_edge_counter #(.RO_CNT_W(RO_CNT_W)) u_edge_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_clk (ro_clk),
    .cur    (cur)
  );

  // Modular difference absorbs wrap of the narrow edge counter, as long
  // as fewer than 2^RO_CNT_W-1 edges arrive per clk cycle.
  assign delta   = cur - prev_q;
  assign sum     = {1'b0, acc_q} + (ACC_W+1)'(delta);
  assign sat_hit = sum[ACC_W];
  assign acc_nxt = sat_hit ? '1 : sum[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + WIN_CNT_W'(1);
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_GATE;
          cnt_d   = '0;
        end
      end
      ST_GATE: begin
        if (cnt_q == win_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
      ro_en   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      ro_en   <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_last_q <= '0;
      prev_q     <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start)
        win_last_q <= WIN_CNT_W'((32'd1 << (32'(win_sel) + WIN_BASE_EXP)) - 32'd1);
      case (state_q)
        ST_SETTLE: begin
          // Track cur so edges from oscillator start-up never count.
          prev_q <= cur;
          acc_q  <= '0;
          sat_q  <= 1'b0;
        end
        ST_GATE: begin
          prev_q <= cur;
          acc_q  <= acc_nxt;
          sat_q  <= sat_q | sat_hit;
        end
        default: ;
      endcase
      // Final gate cycle's delta is folded in directly.
      if (done_d) begin
        result   <= acc_nxt;
        overflow <= sat_q | sat_hit;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ro_freq_meter.sv
`timescale 1ns/1ps
module tb_ro_freq_meter;
  localparam int  S    = 16;
  localparam real TCLK = 10.0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0;
  logic [3:0] ws1 = '0, ws2 = '0;
  logic ro1 = 1'b0, ro2 = 1'b0;
  logic ro_en1, busy1, done1, ovf1;
  logic ro_en2, busy2, done2, ovf2;
  logic [23:0] res1;
  logic [7:0]  res2;
  real h1 = 0.0, h2 = 0.0;   // ro_clk half period, 0 = tied low

  int tests = 0, fails = 0, cyc = 0;

  typedef struct { int due; real lo; real hi; bit ovf; } exp_t;
  exp_t q1[$], q2[$];

  ro_freq_meter #(.RO_CNT_W(8), .ACC_W(24), .SETTLE_CYCLES(S)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .win_sel(ws1), .ro_clk(ro1),
    .ro_en(ro_en1), .busy(busy1), .done(done1), .result(res1), .overflow(ovf1));

  ro_freq_meter #(.RO_CNT_W(8), .ACC_W(8), .SETTLE_CYCLES(S)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .win_sel(ws2), .ro_clk(ro2),
    .ro_en(ro_en2), .busy(busy2), .done(done2), .result(res2), .overflow(ovf2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillators: free-running while enabled, held low otherwise.
  always begin
    if (ro_en1 === 1'b1 && h1 > 0.0) begin #(h1) ro1 = 1'b1; #(h1) ro1 = 1'b0; end
    else begin ro1 = 1'b0; @(ro_en1); end
  end
  always begin
    if (ro_en2 === 1'b1 && h2 > 0.0) begin #(h2) ro2 = 1'b1; #(h2) ro2 = 1'b0; end
    else begin ro2 = 1'b0; @(ro_en2); end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: edges in an N-cycle window = N*Tclk / Tro, +-1 quantisation,
  // clamped to the accumulator maximum.
  function automatic exp_t mk_exp(input int due, input int ws, input real h, input int acc_w);
    exp_t e;
    real  n, edges, mx;
    n     = real'(1 << (ws + 4));
    mx    = real'((longint'(1) << acc_w) - 1);
    edges = (h > 0.0) ? n * TCLK / (2.0 * h) : 0.0;
    e.due = due;
    e.ovf = (edges > mx);
    if (h == 0.0) begin
      e.lo = 0.0; e.hi = 0.0;
    end else begin
      e.lo = (edges - 1.0 > mx) ? mx : ((edges - 1.0 < 0.0) ? 0.0 : edges - 1.0);
      e.hi = (edges + 1.0 > mx) ? mx : edges + 1.0;
    end
    return e;
  endfunction

  task automatic chk_resp(input string nm, input exp_t e, input int act, input bit aovf);
    chk({nm, "_latency"}, cyc, e.due);
    tests++;
    if (real'(act) < e.lo || real'(act) > e.hi) begin
      fails++;
      $display("FAIL %s_result: got %0d expected %0.1f..%0.1f", nm, act, e.lo, e.hi);
    end
    chk({nm, "_overflow"}, aovf, e.ovf);
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut1_unexpected_done: got done=1 expected no done (result %0d)", res1);
      end else chk_resp("dut1", q1.pop_front(), int'(res1), ovf1);
    end
  end
  always @(negedge clk) begin
    if (rst_n && done2 === 1'b1) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut2_unexpected_done: got done=1 expected no done (result %0d)", res2);
      end else chk_resp("dut2", q2.pop_front(), int'(res2), ovf2);
    end
  end

  // Issue a start. With now=1 the caller is already mid-cycle and start is
  // raised in the current cycle; otherwise it is raised in the next cycle.
  task automatic issue(input int which, input int ws, input real h, input bit now);
    int due;
    if (!now) begin @(posedge clk); #1; end
    if (which == 1) begin h1 = h; ws1 = 4'(ws); start1 = 1'b1; end
    else            begin h2 = h; ws2 = 4'(ws); start2 = 1'b1; end
    due = cyc + S + (1 << (ws + 4)) + 1;
    if (which == 1) q1.push_back(mk_exp(due, ws, h, 24));
    else            q2.push_back(mk_exp(due, ws, h, 8));
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    if (which == 1) begin chk("busy1_cycle1", busy1, 1); chk("ro_en1_cycle1", ro_en1, 1); end
    else            begin chk("busy2_cycle1", busy2, 1); chk("ro_en2_cycle1", ro_en2, 1); end
  endtask

  task automatic wait_idle(input int which, input int bound);
    int n = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && n < bound) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    if (((which == 1) ? q1.size() : q2.size()) != 0) begin
      tests++; fails++;
      $display("FAIL timeout_dut%0d: got no done expected done within %0d cycles", which, bound);
      if (which == 1) q1.delete(); else q2.delete();
    end
  endtask

  initial begin
    real hs[6];
    int  ws, n;
    hs[0] = 1.0; hs[1] = 1.5; hs[2] = 2.0; hs[3] = 2.5; hs[4] = 3.5; hs[5] = 5.0;

    // Reset state
    #1;
    chk("rst_ro_en", ro_en1, 0); chk("rst_busy", busy1, 0); chk("rst_done", done1, 0);
    chk("rst_result", res1, 0);  chk("rst_overflow", ovf1, 0); chk("rst_ro_en2", ro_en2, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy1, 0); chk("idle_ro_en", ro_en1, 0);

    // Basic: 4 ns oscillator, 16-cycle window -> 40
    issue(1, 0, 2.0, 0); wait_idle(1, 60);
    // Oscillator tied low -> 0
    issue(1, 2, 0.0, 0); wait_idle(1, 120);
    // Counter wrap: 256-cycle window -> 640
    issue(1, 4, 2.0, 0); wait_idle(1, 300);
    // Saturation on the 8-bit accumulator, then a clean window clears the flag
    issue(2, 3, 0.5, 0); wait_idle(2, 200);
    issue(2, 0, 2.0, 0); wait_idle(2, 60);

    // Start pulses during SETTLE and GATE are ignored
    issue(1, 0, 2.0, 0);
    repeat (4) @(posedge clk); #1 start1 = 1'b1; @(posedge clk); #1 start1 = 1'b0;
    repeat (14) @(posedge clk); #1 start1 = 1'b1; @(posedge clk); #1 start1 = 1'b0;
    wait_idle(1, 60);
    repeat (40) @(posedge clk); #1;
    chk("ignored_start_busy", busy1, 0);

    // Start coincident with done is accepted
    issue(1, 0, 2.0, 0);
    n = 0;
    while (done1 !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("done_seen_for_backtoback", done1, 1);
    issue(1, 1, 2.5, 1);
    wait_idle(1, 80);

    // Randomised windows and oscillator periods
    for (int i = 0; i < 6; i++) begin
      ws = int'($urandom_range(0, 5));
      issue(1, ws, hs[$urandom_range(0, 5)], 0);
      wait_idle(1, (1 << (ws + 4)) + 40);
    end

    // Reset mid-GATE: immediate abort, no done, then a clean measurement
    issue(1, 2, 2.0, 0);
    repeat (S + 20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_ro_en", ro_en1, 0); chk("abort_busy", busy1, 0);
    chk("abort_result", res1, 0);  chk("abort_overflow", ovf1, 0);
    q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_no_restart", busy1, 0);
    issue(1, 0, 2.0, 0); wait_idle(1, 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Measures the frequency of an on-chip ring oscillator against the system clock. Enables the oscillator for a settle interval and then a programmable gate window. Counts oscillator rising edges in the oscillator domain with a Gray-coded counter and accumulates them in the `clk` domain. Reports a saturating edge count per window. Sits directly downstream of the ring oscillator: drives its enable and consumes its `clk_out`.

## Interface
- `RO_CNT_W`, default 8: width of the Gray edge counter clocked by `ro_clk`.
- `ACC_W`, default 24: width of the result accumulator.
- `SETTLE_CYCLES`, default 16: `clk` cycles between `ro_en` rising and gate start.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a measurement; sampled only when not busy.
- `win_sel`, input, 4: gate window N = 2^(win_sel+4) `clk` cycles (16 … 524288); latched at accepted start.
- `ro_clk`, input, 1: oscillator output; asynchronous to `clk`; held 0 when disabled.
- `ro_en`, output, 1: oscillator enable, registered.
- `busy`, output, 1: high from the cycle after an accepted start until the window ends.
- `done`, output, 1: single-cycle pulse when `result` updates.
- `result`, output, ACC_W: rising `ro_clk` edges counted in the last window.
- `overflow`, output, 1: the last window saturated `result`.

## Operation
- States:
  - IDLE → SETTLE on `start`.
  - SETTLE → GATE after SETTLE_CYCLES cycles.
  - GATE → IDLE after N cycles, pulsing `done`.
- Oscillator domain:
  - Binary counter increments on each `ro_clk` rising edge and is re-encoded to Gray into a register.
  - The Gray register is synchronised by two `clk` flops, then converted back to binary (`cur`).
- SETTLE:
  - `ro_en`=1; accumulator and overflow cleared.
  - `prev` <= `cur` every cycle, discarding start-up edges.
- GATE: every cycle, `delta` = (`cur` − `prev`) mod 2^RO_CNT_W; `prev` <= `cur`; acc <= min(acc + delta, 2^ACC_W−1).
- Saturation sets a sticky internal flag; acc holds all-ones.
- GATE exit:
  - `result` <= acc, `overflow` <= flag, `done`=1 for one cycle.
  - `ro_en` <= 0 and state returns to IDLE.
- `result`/`overflow` hold until the next `done`.
- `start` while `busy` is ignored (no queueing).
- `start` in the cycle `done` is high is accepted.
- Valid range: fewer than 2^RO_CNT_W−1 oscillator edges per `clk` cycle; beyond that the result is undefined, not flagged.

## Timing
- Reset values:
  - `ro_en`=0, `busy`=0, `done`=0, `result`=0, `overflow`=0, state IDLE.
  - Edge counter, Gray register and synchroniser all 0.
- `rst_n` also asynchronously clears the `ro_clk`-domain counter.
- Deassertion is safe because `ro_en`=0 holds `ro_clk` low.
- With `start` high in cycle 0:
  - `busy`=1 and `ro_en`=1 from cycle 1.
  - GATE occupies cycles 1+SETTLE_CYCLES … SETTLE_CYCLES+N.
  - `done` is in cycle SETTLE_CYCLES+N+1, where `busy`=0.
- Total latency from start to done: SETTLE_CYCLES+N+1 cycles.
- The 2-cycle synchroniser lag applies equally to window start and end; quantisation error is ±1 edge.
- Reset mid-operation:
  - Immediate abort; `ro_en` drops asynchronously.
  - `result`/`overflow` are cleared, and no `done` is issued.

## Structure
- Shared package `ro_meter_pkg`:
  - state encoding (IDLE, SETTLE, GATE);
  - window base exponent 4;
  - Gray↔binary conversion functions.
- One sub-module, `ro_edge_counter`:
  - `ro_clk`-domain binary+Gray counter plus the 2-flop `clk`-domain synchroniser;
  - outputs binary `cur`;
  - the only logic clocked by `ro_clk`.
- Window counter: 20 bits.

## Test plan
- `clk` 10 ns, `ro_clk` 4 ns period, `win_sel`=0 → `done` exactly 33 cycles after start; `result` 40±1; `overflow`=0.
- `ro_clk` tied 0, `win_sel`=2 → `result`=0 after 16+64+1 cycles.
- Counter-wrap check: `win_sel`=4 (256 cycles), `ro_clk` 4 ns → `result` 640±1.
- Saturation: ACC_W=8, `ro_clk` 1 ns, `win_sel`=3 → `result`=255, `overflow`=1.
- Start pulses during SETTLE and GATE are ignored (single `done`). Start coincident with `done` is accepted: `busy` is high the next cycle.
- `rst_n` pulled low mid-GATE:
  - `ro_en`/`busy`/`result` go 0 immediately, with no `done`.
  - A following measurement at `ro_clk` 4 ns, `win_sel`=0 gives 40±1.
